// File: rtl/uart_rx_parity.sv
// uart_rx_parity: 8E1 UART receiver (start, 8 data LSB first, even parity, stop) with error flags and state LEDs.
// Latency: VALID pulses 1 CLK after the mid-stop decision (2 CLK synchronizer + ~10.5 bit times from start edge).
// Backpressure: none; VALID is a one-cycle pulse, DATA/PARITY_ERR/FRAME_ERR hold until the next frame completes.
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit's sample point.
`timescale 1ns/1ps
module uart_rx_parity #(
    parameter int CLK_FREQ  = 125_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR,
    output logic       BUSY,
    output logic       LED_IDLE,
    output logic       LED_DATA,
    output logic       LED_ERR
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ_D        = CLKS_PER_BIT / 16;
    // Decision moves to the third sample; later states stay aligned because entry is D late too.
    localparam int START_DEC    = HALF_BIT - 1 + MAJ_D;
`else
    localparam int START_DEC    = HALF_BIT - 1;
`endif
    localparam int BIT_DEC      = CLKS_PER_BIT - 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic             rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_bit_err_q, par_bit_err_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             dec_pt;   // cycle on which the current bit is decided
    logic             bit_val;  // decided bit value

`ifdef UART_RX_MAJORITY_EN
    logic             maj_a_q, maj_a_d;
    logic             maj_b_q, maj_b_d;
    logic [CNT_W-1:0] dec_cnt;

    // Capture the two early samples, vote with the live sample on the decision cycle.
    always_comb begin
        dec_cnt = (state_q == ST_START) ? CNT_W'(START_DEC) : CNT_W'(BIT_DEC);
        maj_a_d = maj_a_q;
        maj_b_d = maj_b_q;
        if (baud_cnt_q == dec_cnt - CNT_W'(2 * MAJ_D)) maj_a_d = rx_s_q;
        if (baud_cnt_q == dec_cnt - CNT_W'(MAJ_D))     maj_b_d = rx_s_q;
        dec_pt  = (baud_cnt_q == dec_cnt);
        bit_val = (maj_a_q & maj_b_q) | (maj_a_q & rx_s_q) | (maj_b_q & rx_s_q);
    end

    // Majority sample registers; idle-high like the line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            maj_a_q <= 1'b1;
            maj_b_q <= 1'b1;
        end else begin
            maj_a_q <= maj_a_d;
            maj_b_q <= maj_b_d;
        end
    end
`else
    // Single sample: the bit is whatever the synchronized line shows at the sample point.
    always_comb begin
        dec_pt  = (state_q == ST_START) ? (baud_cnt_q == CNT_W'(START_DEC))
                                        : (baud_cnt_q == CNT_W'(BIT_DEC));
        bit_val = rx_s_q;
    end
`endif

    // Next-state, datapath and baud counter; counter restarts on every state change.
    always_comb begin
        rx_meta_d     = RXD;
        rx_s_d        = rx_meta_q;
        rx_prev_d     = rx_s_q;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        par_bit_err_d = par_bit_err_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        parity_err_d  = parity_err_q;
        frame_err_d   = frame_err_q;
        baud_cnt_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                if (dec_pt) begin
                    if (bit_val) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (dec_pt) begin
                    shreg_d   = {bit_val, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (dec_pt) begin
                    par_bit_err_d = bit_val ^ (^shreg_q);
                    state_d       = ST_STOP;
                end
            end
            ST_STOP: begin
                if (dec_pt) begin
                    data_d       = shreg_q;
                    parity_err_d = par_bit_err_q;
                    frame_err_d  = ~bit_val;
                    valid_d      = 1'b1;
                    state_d      = bit_val ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q)                   baud_cnt_d = '0;
        else if (baud_cnt_q == CNT_W'(BIT_DEC))   baud_cnt_d = '0;
        else                                      baud_cnt_d = baud_cnt_q + CNT_W'(1);
    end

    // State and datapath registers; synchronizer resets to the idle-high line level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            baud_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            par_bit_err_q <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            rx_prev_q     <= rx_prev_d;
            baud_cnt_q    <= baud_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            par_bit_err_q <= par_bit_err_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Outputs straight from registers / state decode.
    always_comb begin
        DATA       = data_q;
        VALID      = valid_q;
        PARITY_ERR = parity_err_q;
        FRAME_ERR  = frame_err_q;
        BUSY       = (state_q != ST_IDLE);
        LED_IDLE   = (state_q == ST_IDLE);
        LED_DATA   = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP);
        LED_ERR    = (state_q == ST_WAIT_HIGH);
    end
endmodule

// File: tb/tb_uart_rx_parity.sv
// tb_uart_rx_parity: drives 8E1 frames onto RXD and scoreboards VALID/DATA/error flags.
// Latency: expected VALID cycle derived from start edge, 2-flop sync and mid-stop sampling.
// Backpressure: none; monitor pops one expectation per VALID pulse.
`timescale 1ns/1ps
module tb_uart_rx_parity;
    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD_RATE = 100_000;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT_EXTRA = CPB / 16;
`else
    localparam int LAT_EXTRA = 0;
`endif
    // RXD falls before posedge k; start seen after 2 sync flops + edge detect, VALID 1 CLK after mid-stop.
    localparam int VALID_LAT = 3 + HALF + 10 * CPB + LAT_EXTRA;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RXD;
    logic [7:0] DATA;
    logic       VALID, PARITY_ERR, FRAME_ERR, BUSY, LED_IDLE, LED_DATA, LED_ERR;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         sc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    uart_rx_parity #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .CLK(CLK), .RST(RST), .RXD(RXD), .DATA(DATA), .VALID(VALID),
        .PARITY_ERR(PARITY_ERR), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY),
        .LED_IDLE(LED_IDLE), .LED_DATA(LED_DATA), .LED_ERR(LED_ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: one expectation per VALID; VALID must drop the following cycle.
    initial begin
        exp_t e;
        logic chk_next;
        int   lat;
        chk_next = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (chk_next) begin
                check_eq("valid_width", VALID, 0);
                chk_next = 1'b0;
            end
            if (VALID === 1'b1) begin
                chk_next = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual DATA=0x%0h expected no VALID at cycle %0d", DATA, cyc);
                end else begin
                    e = sb.pop_front();
                    check_eq("data", DATA, e.d);
                    check_eq("parity_err", PARITY_ERR, e.pe);
                    check_eq("frame_err", FRAME_ERR, e.fe);
                    lat = cyc - e.sc;
                    check_eq("valid_latency",
                             (lat >= VALID_LAT - 1 && lat <= VALID_LAT + 1) ? VALID_LAT : lat,
                             VALID_LAT);
                end
            end
        end
    end

    // Reference: even parity means the sent bit makes the total count of ones even.
    task automatic send_frame(input logic [7:0] b, input logic pbad, input logic stopb);
        logic [10:0] fr;
        logic        pbit;
        exp_t        e;
        pbit  = (($countones(b) % 2) == 1) ^ pbad;
        fr    = {stopb, pbit, b, 1'b0};
        e.d   = b;
        e.pe  = ((($countones(b) + pbit) % 2) != 0);
        e.fe  = ~stopb;
        e.sc  = cyc;
        sb.push_back(e);
        for (int i = 0; i < 11; i++) begin
            RXD = fr[i];
            if (i == 5) begin
                repeat (HALF) @(negedge CLK);
                check_eq("busy_led_mid_frame", {BUSY, LED_DATA}, 2'b11);
                repeat (CPB - HALF) @(negedge CLK);
            end else begin
                repeat (CPB) @(negedge CLK);
            end
        end
    endtask

    task automatic idle(input int n);
        RXD = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        logic [7:0] b;
        logic       pbad, stopb;

        RST = 1'b0;
        RXD = 1'b1;
        repeat (5) @(negedge CLK);
        check_eq("rst_data", DATA, 0);
        check_eq("rst_valid", VALID, 0);
        check_eq("rst_perr", PARITY_ERR, 0);
        check_eq("rst_ferr", FRAME_ERR, 0);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_led_idle", LED_IDLE, 1);
        RST = 1'b1;
        idle(2 * CPB);

        // Clean 'A', then idle state.
        send_frame(8'h41, 1'b0, 1'b1);
        idle(CPB);
        check_eq("idle_after_frame", {BUSY, LED_IDLE}, 2'b01);

        // Parity error is sticky until the next good frame.
        send_frame(8'h41, 1'b1, 1'b1);
        idle(3 * CPB);
        check_eq("perr_sticky", PARITY_ERR, 1);
        send_frame(8'h4F, 1'b0, 1'b1);
        idle(CPB);
        check_eq("perr_cleared", PARITY_ERR, 0);

        // Framing error with line held low (break), then recovery.
        send_frame(8'h45, 1'b0, 1'b0);
        RXD = 1'b0;
        repeat (10 * CPB) @(negedge CLK);
        check_eq("break_led_err", {LED_ERR, BUSY, FRAME_ERR}, 3'b111);
        repeat (10 * CPB) @(negedge CLK);
        idle(2 * CPB);
        check_eq("break_recovered", {LED_ERR, LED_IDLE}, 2'b01);
        send_frame(8'h42, 1'b0, 1'b1);
        idle(CPB);
        check_eq("ferr_cleared", FRAME_ERR, 0);

        // Short low glitch: START entered then abandoned.
        RXD = 1'b0;
        repeat (4) @(negedge CLK);
        check_eq("glitch_start", BUSY, 1);
        repeat (HALF - 7) @(negedge CLK);
        idle(2 * CPB);
        check_eq("glitch_idle", BUSY, 0);
        check_eq("glitch_data_held", DATA, 8'h42);

        // Back-to-back frames with no gap.
        send_frame(8'h4F, 1'b0, 1'b1);
        send_frame(8'h40, 1'b0, 1'b1);
        idle(CPB);

        // Reset in the middle of bit 4 of 0x43.
        b = 8'h43;
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RXD = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RXD = b[4];
        repeat (HALF) @(negedge CLK);
        RST = 1'b0;
        #1;
        check_eq("midrst_data", DATA, 0);
        check_eq("midrst_flags", {VALID, PARITY_ERR, FRAME_ERR, BUSY}, 0);
        @(negedge CLK);
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        idle(2 * CPB);
        send_frame(8'h43, 1'b0, 1'b1);
        idle(CPB);

        // Randomized frames with occasional parity/framing errors and random gaps.
        for (int n = 0; n < 40; n++) begin
            b     = 8'($urandom);
            pbad  = ($urandom_range(0, 4) == 0);
            stopb = ($urandom_range(0, 5) != 0);
            send_frame(b, pbad, stopb);
            if (!stopb) begin
                RXD = 1'b0;
                repeat ($urandom_range(1, 3) * CPB) @(negedge CLK);
                idle(2 * CPB);
            end else begin
                idle($urandom_range(0, 2) * CPB);
            end
        end

        idle(4 * CPB);
        check_eq("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
